// File: rtl/dma_xy_sequencer.sv
// Control sequencer for a single 2-D DMA block transfer: xlen beats per row, ylen rows,
// with beat/row skip, read-modify-write and bus re-arbitration on page crossings.
module dma_xy_sequencer #(
    parameter int X_W = 4,
    parameter int Y_W = 8
) (
    input  logic           clk,
    input  logic           resetb,
    input  logic           start,
    input  logic [X_W-1:0] xlen,
    input  logic [Y_W-1:0] ylen,
    input  logic           rmwb,
    input  logic           xskip,
    input  logic           yskip,
    input  logic           page,
    input  logic           busgnt,
    input  logic           ack,
    output logic           busy,
    output logic           busreq,
    output logic           rd,
    output logic           wr,
    output logic [2:0]     adctlpb,
    output logic [3:0]     dmpst,
    output logic           done
);

    localparam logic [3:0] S_IDLE  = 4'h0;
    localparam logic [3:0] S_LOAD  = 4'h1;
    localparam logic [3:0] S_REQ   = 4'h2;
    localparam logic [3:0] S_ROW   = 4'h3;
    localparam logic [3:0] S_BEAT  = 4'h4;
    localparam logic [3:0] S_RD    = 4'h5;
    localparam logic [3:0] S_MOD   = 4'h6;
    localparam logic [3:0] S_WR    = 4'h7;
    localparam logic [3:0] S_XSTEP = 4'h8;
    localparam logic [3:0] S_YSTEP = 4'h9;
    localparam logic [3:0] S_PAGE  = 4'hA;
    localparam logic [3:0] S_DONE  = 4'hB;

    localparam logic [2:0] AD_HOLD = 3'b000;
    localparam logic [2:0] AD_LOAD = 3'b001;
    localparam logic [2:0] AD_INCX = 3'b010;
    localparam logic [2:0] AD_INCY = 3'b011;
    localparam logic [2:0] AD_PAGE = 3'b100;

    localparam logic [X_W-1:0] X_ONE = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

    logic [3:0]     state, nxt;
    logic [X_W-1:0] xcnt, xlen_q;
    logic [Y_W-1:0] ycnt;
    logic           resume_beat;
    logic [2:0]     adctl;

    always_comb begin
        nxt = S_IDLE;
        case (state)
            S_IDLE:  nxt = start ? S_LOAD : S_IDLE;
            S_LOAD:  nxt = (xlen == '0 || ylen == '0) ? S_DONE : S_REQ;
            S_REQ:   nxt = !busgnt ? S_REQ : (resume_beat ? S_BEAT : S_ROW);
            S_ROW:   nxt = yskip ? S_YSTEP : S_BEAT;
            S_BEAT:  nxt = xskip ? S_XSTEP : S_RD;
            S_RD:    nxt = !ack ? S_RD : (rmwb ? S_XSTEP : S_MOD);
            S_MOD:   nxt = S_WR;
            S_WR:    nxt = ack ? S_XSTEP : S_WR;
            S_XSTEP: nxt = (xcnt == X_ONE) ? S_YSTEP : (page ? S_PAGE : S_BEAT);
            S_YSTEP: nxt = (ycnt == Y_ONE) ? S_DONE : (page ? S_PAGE : S_ROW);
            S_PAGE:  nxt = S_REQ;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // resume_beat picks where REQ goes after a page break: mid-row back to BEAT, row end to ROW
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state       <= S_IDLE;
            xcnt        <= '0;
            ycnt        <= '0;
            xlen_q      <= '0;
            resume_beat <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                S_LOAD: begin
                    xcnt        <= xlen;
                    ycnt        <= ylen;
                    xlen_q      <= xlen;
                    resume_beat <= 1'b0;
                end
                S_XSTEP: if (xcnt > X_ONE) begin
                    xcnt <= xcnt - X_ONE;
                    if (page) resume_beat <= 1'b1;
                end
                S_YSTEP: if (ycnt > Y_ONE) begin
                    ycnt <= ycnt - Y_ONE;
                    xcnt <= xlen_q;
                    if (page) resume_beat <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        adctl  = AD_HOLD;
        busreq = 1'b0;
        case (state)
            S_LOAD:  adctl = AD_LOAD;
            S_XSTEP: adctl = AD_INCX;
            S_YSTEP: adctl = AD_INCY;
            S_PAGE:  adctl = AD_PAGE;
            default: adctl = AD_HOLD;
        endcase
        case (state)
            S_REQ, S_ROW, S_BEAT, S_RD, S_MOD, S_WR, S_XSTEP, S_YSTEP: busreq = 1'b1;
            default: busreq = 1'b0;
        endcase
    end

    assign adctlpb = ~adctl;
    assign dmpst   = state;
    assign busy    = (state != S_IDLE);
    assign rd      = (state == S_RD);
    assign wr      = (state == S_WR);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_dma_xy_sequencer.sv
// Directed bench for dma_xy_sequencer: bus/page/skip responders live in tick(), each
// scenario task drives a transfer and checks traces and counts it collected.
module tb_dma_xy_sequencer;

    logic       clk = 1'b0;
    logic       resetb = 1'b0, start = 1'b0, rmwb = 1'b1, xskip = 1'b0, yskip = 1'b0;
    logic       page = 1'b0, busgnt = 1'b1, ack = 1'b0;
    logic [3:0] xlen = '0;
    logic [7:0] ylen = '0;
    logic       busy, busreq, rd, wr, done;
    logic [2:0] adctlpb;
    logic [3:0] dmpst;

    dma_xy_sequencer #(.X_W(4), .Y_W(8)) dut (
        .clk(clk), .resetb(resetb), .start(start), .xlen(xlen), .ylen(ylen),
        .rmwb(rmwb), .xskip(xskip), .yskip(yskip), .page(page), .busgnt(busgnt),
        .ack(ack), .busy(busy), .busreq(busreq), .rd(rd), .wr(wr),
        .adctlpb(adctlpb), .dmpst(dmpst), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc_n = 0, done_n, rd_n, wr_n, page_n, req_after_page, ack_wait, req_run;
    int xstep_n, row_n, wr_first, rd_ack_cyc;
    bit breq_seen, overlap, page_breq;
    bit auto_ack = 1'b1, gnt_hold = 1'b0, page_mode = 1'b0, yskip_mode = 1'b0;
    logic [127:0] trace_v;
    logic [63:0]  adc_v;
    logic [3:0]   last_st;

    // One cycle: sample outputs at the falling edge, then set up responder inputs for the next rise
    task automatic tick();
        @(negedge clk);
        cyc_n++;
        if (dmpst != last_st) begin
            trace_v = {trace_v[123:0], dmpst};
            last_st = dmpst;
        end
        if (adctlpb != 3'b111) adc_v = {adc_v[60:0], ~adctlpb};
        if (done) done_n++;
        if (busreq) breq_seen = 1'b1;
        if (rd && wr) overlap = 1'b1;
        if (dmpst == 4'hA) begin
            page_n++;
            if (busreq) page_breq = 1'b1;
        end
        if (page_n > 0 && dmpst == 4'h2) req_after_page++;
        if (wr && wr_first < 0) wr_first = cyc_n;
        if ((rd || wr) && auto_ack && !ack) begin
            if (ack_wait == 1) begin
                ack = 1'b1;
                ack_wait = 0;
                if (rd) begin rd_n++; rd_ack_cyc = cyc_n; end
                else wr_n++;
            end else ack_wait++;
        end else begin
            ack = 1'b0;
            ack_wait = 0;
        end
        if (gnt_hold) begin
            if (dmpst == 4'h2) begin
                req_run++;
                busgnt = (req_run > 5);
            end else begin
                req_run = 0;
                busgnt = 1'b0;
            end
        end else busgnt = 1'b1;
        if (dmpst == 4'h8) begin
            page = page_mode && xstep_n == 0;
            xstep_n++;
        end else page = 1'b0;
        if (dmpst == 4'h3) begin
            yskip = yskip_mode && row_n == 1;
            row_n++;
        end else yskip = 1'b0;
    endtask

    task automatic clear();
        done_n = 0; rd_n = 0; wr_n = 0; page_n = 0; req_after_page = 0; ack_wait = 0;
        req_run = 0; xstep_n = 0; row_n = 0; wr_first = -1; rd_ack_cyc = -1;
        breq_seen = 1'b0; overlap = 1'b0; page_breq = 1'b0;
        trace_v = '0; adc_v = '0; last_st = dmpst;
    endtask

    task automatic start_xfer(input logic [3:0] xl, input logic [7:0] yl, input logic rm);
        clear();
        xlen = xl; ylen = yl; rmwb = rm; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 300) begin tick(); k++; end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s timeout: busy=%b still set after %0d cycles, required 0", name, busy, k);
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        tick(); tick();
        n_chk++;
        if ({busy, busreq, rd, wr, done} !== 5'b0) begin
            n_fail++; $display("FAIL reset strobes: got %b required 00000", {busy, busreq, rd, wr, done});
        end
        n_chk++;
        if (adctlpb !== 3'b111) begin
            n_fail++; $display("FAIL reset adctlpb: got %b required 111", adctlpb);
        end
        n_chk++;
        if (dmpst !== 4'h0) begin
            n_fail++; $display("FAIL reset dmpst: got %h required 0", dmpst);
        end
        resetb = 1'b1;
        tick();
    endtask

    task automatic test_read_2x2();
        start_xfer(4'd2, 8'd2, 1'b1);
        wait_idle("read_2x2");
        n_chk++;
        if (rd_n != 4 || wr_n != 0) begin
            n_fail++; $display("FAIL read_2x2 accesses: got rd=%0d wr=%0d required rd=4 wr=0", rd_n, wr_n);
        end
        n_chk++;
        if (adc_v !== 64'o1223223) begin
            n_fail++; $display("FAIL read_2x2 adctl order: got %o required 1223223", adc_v);
        end
        n_chk++;
        if (done_n != 1) begin
            n_fail++; $display("FAIL read_2x2 done count: got %0d required 1", done_n);
        end
        n_chk++;
        if (overlap) begin
            n_fail++; $display("FAIL read_2x2 rd/wr overlap: got 1 required 0");
        end
    endtask

    task automatic test_rmw_1x1();
        start_xfer(4'd1, 8'd1, 1'b0);
        wait_idle("rmw_1x1");
        n_chk++;
        if (trace_v !== 128'h123456789B0) begin
            n_fail++; $display("FAIL rmw_1x1 state trace: got %h required 123456789b0", trace_v);
        end
        n_chk++;
        if (wr_first - rd_ack_cyc != 2) begin
            n_fail++; $display("FAIL rmw_1x1 wr delay: got %0d required 2", wr_first - rd_ack_cyc);
        end
        n_chk++;
        if (rd_n != 1 || wr_n != 1 || done_n != 1) begin
            n_fail++; $display("FAIL rmw_1x1 counts: got rd=%0d wr=%0d done=%0d required 1 1 1", rd_n, wr_n, done_n);
        end
    endtask

    task automatic test_zero_len();
        clear();
        n_chk++;
        if (dmpst !== 4'h0) begin
            n_fail++; $display("FAIL zero_len c0 dmpst: got %h required 0", dmpst);
        end
        xlen = 4'd0; ylen = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        n_chk++;
        if (dmpst !== 4'h1) begin
            n_fail++; $display("FAIL zero_len c1 dmpst: got %h required 1", dmpst);
        end
        tick();
        n_chk++;
        if (dmpst !== 4'hB || done !== 1'b1) begin
            n_fail++; $display("FAIL zero_len c2: got dmpst=%h done=%b required b 1", dmpst, done);
        end
        tick();
        n_chk++;
        if (dmpst !== 4'h0 || done !== 1'b0) begin
            n_fail++; $display("FAIL zero_len c3: got dmpst=%h done=%b required 0 0", dmpst, done);
        end
        n_chk++;
        if (breq_seen || done_n != 1) begin
            n_fail++; $display("FAIL zero_len busreq/done: got busreq_seen=%b done=%0d required 0 1", breq_seen, done_n);
        end
    endtask

    task automatic test_page_break();
        gnt_hold = 1'b1; page_mode = 1'b1;
        start_xfer(4'd3, 8'd1, 1'b1);
        wait_idle("page_break");
        gnt_hold = 1'b0; page_mode = 1'b0;
        n_chk++;
        if (trace_v !== 128'h123458A24584589B0) begin
            n_fail++; $display("FAIL page_break state trace: got %h required 123458a24584589b0", trace_v);
        end
        n_chk++;
        if (page_n != 1 || page_breq) begin
            n_fail++; $display("FAIL page_break page: got cycles=%0d busreq=%b required 1 0", page_n, page_breq);
        end
        n_chk++;
        if (req_after_page != 6) begin
            n_fail++; $display("FAIL page_break rearb wait: got %0d REQ cycles required 6", req_after_page);
        end
        n_chk++;
        if (rd_n != 3 || done_n != 1) begin
            n_fail++; $display("FAIL page_break counts: got rd=%0d done=%0d required 3 1", rd_n, done_n);
        end
    endtask

    task automatic test_row_skip();
        yskip_mode = 1'b1;
        start_xfer(4'd2, 8'd3, 1'b1);
        wait_idle("row_skip");
        yskip_mode = 1'b0;
        n_chk++;
        if (rd_n != 4) begin
            n_fail++; $display("FAIL row_skip rd count: got %0d required 4", rd_n);
        end
        n_chk++;
        if (adc_v !== 64'o12233223) begin
            n_fail++; $display("FAIL row_skip adctl order: got %o required 12233223", adc_v);
        end
        n_chk++;
        if (done_n != 1) begin
            n_fail++; $display("FAIL row_skip done count: got %0d required 1", done_n);
        end
    endtask

    task automatic test_reset_mid_write();
        int k = 0;
        auto_ack = 1'b0;
        start_xfer(4'd1, 8'd1, 1'b0);
        while (!wr && k < 50) begin
            // no ack: a manual one moves RD on to MOD/WR
            ack = rd;
            tick(); k++;
        end
        ack = 1'b0;
        n_chk++;
        if (wr !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid wr reach: got wr=%b required 1", wr);
        end
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        n_chk++;
        if (dmpst !== 4'h0 || wr !== 1'b0 || busreq !== 1'b0 || adctlpb !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got dmpst=%h wr=%b busreq=%b adctlpb=%b required 0 0 0 111",
                     dmpst, wr, busreq, adctlpb);
        end
        tick();
        n_chk++;
        if (done_n != 0 || dmpst !== 4'h0) begin
            n_fail++; $display("FAIL reset_mid no done: got done=%0d dmpst=%h required 0 0", done_n, dmpst);
        end
        auto_ack = 1'b1;
        start_xfer(4'd1, 8'd1, 1'b0);
        wait_idle("reset_restart");
        n_chk++;
        if (rd_n != 1 || wr_n != 1 || done_n != 1) begin
            n_fail++; $display("FAIL reset_restart counts: got rd=%0d wr=%0d done=%0d required 1 1 1", rd_n, wr_n, done_n);
        end
    endtask

    initial begin
        clear();
        test_reset();
        test_read_2x2();
        test_rmw_1x1();
        test_zero_len();
        test_page_break();
        test_row_skip();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
